// File: rtl/vertex_fetch_stream_if.sv
// -----------------------------------------------------------------------------
// vertex_fetch_stream_if
// Output stream of the vertex fetcher: one fetched vertex per transfer.
// Signal names are seen from the fetcher's side.
//   valid_out      fetcher -> sink  head entry is valid
//   ready_in       sink -> fetcher  sink accepts the head entry this cycle
//   vertex_id_out  fetcher -> sink  vertex id of the head entry
//   material_out   fetcher -> sink  material id of the head entry
//   attr_out       fetcher -> sink  packed {position, normal} attribute word
// A transfer happens on a rising edge where valid_out && ready_in.
// -----------------------------------------------------------------------------
interface vertex_fetch_stream_if #(
  parameter int ID_WIDTH   = 12,
  parameter int ATTR_WIDTH = 192
);
  logic                  valid_out;
  logic                  ready_in;
  logic [ID_WIDTH-1:0]   vertex_id_out;
  logic [ID_WIDTH-1:0]   material_out;
  logic [ATTR_WIDTH-1:0] attr_out;

  modport master (
    output valid_out, vertex_id_out, material_out, attr_out,
    input  ready_in
  );

  modport slave (
    input  valid_out, vertex_id_out, material_out, attr_out,
    output ready_in
  );
endinterface

// File: rtl/vertex_fetch_stream.sv
// -----------------------------------------------------------------------------
// vertex_fetch_stream
// Walks an index list in index memory, fetches the referenced vertex
// attributes from vertex memory and streams {vertex_id, material, attr} out
// through a small FIFO. A run ends on the all-ones terminator id or after
// max_count vertices.
//
// Ports
//   clk_in, rst_in        clock, asynchronous active-high reset
//   start_in              one-cycle pulse, starts a run when idle
//   first_index_in        first index address of the run
//   max_count_in          vertex limit of the run (0 = unlimited)
//   index_addr_out/_en    index-memory read request
//   index_data_in         {vertex_id, material_id}, MEM_LATENCY after request
//   vertex_addr_out/_en   vertex-memory read request
//   vertex_data_in        attribute word, MEM_LATENCY after request
//   out_if                output stream (valid/ready + payload)
//   busy_out, done_out    run active / one-cycle end-of-run pulse
//   emitted_out           vertices transferred in current/last run
// -----------------------------------------------------------------------------
module vertex_fetch_stream #(
  parameter int ID_WIDTH    = 12,
  parameter int ATTR_WIDTH  = 192,
  parameter int INDEX_AW    = 10,
  parameter int VERTEX_AW   = 10,
  parameter int MEM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    start_in,
  input  logic [INDEX_AW-1:0]     first_index_in,
  input  logic [15:0]             max_count_in,
  output logic [INDEX_AW-1:0]     index_addr_out,
  output logic                    index_en_out,
  input  logic [2*ID_WIDTH-1:0]   index_data_in,
  output logic [VERTEX_AW-1:0]    vertex_addr_out,
  output logic                    vertex_en_out,
  input  logic [ATTR_WIDTH-1:0]   vertex_data_in,
  vertex_fetch_stream_if.master   out_if,
  output logic                    busy_out,
  output logic                    done_out,
  output logic [15:0]             emitted_out
);

  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int RES_W   = FIFO_AW + 1;
  localparam logic [RES_W-1:0] DEPTH_C = RES_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_e;

  typedef struct packed {
    logic [ID_WIDTH-1:0] vid;
    logic [ID_WIDTH-1:0] mat;
  } tag_t;

  typedef struct packed {
    tag_t                  tag;
    logic [ATTR_WIDTH-1:0] attr;
  } entry_t;

  state_e                state_q, state_d;
  logic [INDEX_AW-1:0]   idx_addr_q, idx_addr_d;
  logic [RES_W-1:0]      reserved_q, reserved_d;
  logic                  stop_q, stop_d;
  logic [15:0]           accepted_q, accepted_d;
  logic [15:0]           max_q, max_d;
  logic [15:0]           emitted_q, emitted_d;
  logic [FIFO_AW:0]      wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]      rd_ptr_q, rd_ptr_d;

  // In-flight trackers: bit i set means a read issued i+1 cycles ago.
  logic [MEM_LATENCY-1:0] idx_pipe_q;
  logic [MEM_LATENCY-1:0] vtx_pipe_q;
  tag_t                   tag_pipe_q [MEM_LATENCY];

  entry_t                 fifo_mem_q [FIFO_DEPTH];
  entry_t                 head;

  logic                start_acc, idx_ret, is_term, live_ret, acc_ret;
  logic                hit_max, stop_now, squash, fetch_issue;
  logic                vtx_push, fifo_empty, xfer, in_flight, drain_done;
  logic [ID_WIDTH-1:0] ret_vid, ret_mat;
  logic [15:0]         acc_next;

  // ---------------------------------------------------------------------------
  // Index return decode and request generation
  // ---------------------------------------------------------------------------
  assign start_acc = (state_q == S_IDLE) && start_in && !rst_in;
  assign idx_ret   = idx_pipe_q[MEM_LATENCY-1];
  assign ret_vid   = index_data_in[2*ID_WIDTH-1:ID_WIDTH];
  assign ret_mat   = index_data_in[ID_WIDTH-1:0];
  assign is_term   = &ret_vid;
  assign live_ret  = idx_ret && !stop_q;
  assign acc_ret   = live_ret && !is_term;
  assign acc_next  = accepted_q + 16'd1;
  assign hit_max   = acc_ret && (max_q != '0) && (acc_next == max_q);
  assign stop_now  = (live_ret && is_term) || hit_max;
  assign squash    = idx_ret && !acc_ret;

  // The first index read goes out in the start cycle itself; the stop decided
  // by this cycle's return already blocks this cycle's issue, which keeps an
  // empty run short.
  assign fetch_issue = (state_q == S_FETCH) && !stop_q && !stop_now &&
                       (reserved_q < DEPTH_C);

  assign index_en_out    = start_acc || fetch_issue;
  assign index_addr_out  = start_acc ? first_index_in : idx_addr_q;
  assign vertex_en_out   = acc_ret;
  assign vertex_addr_out = acc_ret ? ret_vid[VERTEX_AW-1:0] : '0;

  // ---------------------------------------------------------------------------
  // FIFO status and output stream
  // ---------------------------------------------------------------------------
  assign vtx_push   = vtx_pipe_q[MEM_LATENCY-1];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign head       = fifo_mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign xfer       = !fifo_empty && out_if.ready_in;

  assign out_if.valid_out     = !fifo_empty;
  assign out_if.vertex_id_out = head.tag.vid;
  assign out_if.material_out  = head.tag.mat;
  assign out_if.attr_out      = head.attr;

  assign in_flight  = (|idx_pipe_q) || (|vtx_pipe_q);
  assign drain_done = (state_q == S_DRAIN) && !in_flight && fifo_empty;

  assign busy_out    = (state_q != S_IDLE);
  assign emitted_out = emitted_q;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    // NOTE: every sequential assignment uses <= so all registers sample the
    // pre-edge values together, independent of statement order.
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch
    // is inferred.
    state_d  = state_q;
    done_out = 1'b0;
    case (state_q)
      S_IDLE:  if (start_acc) state_d = S_FETCH;
      S_FETCH: if (stop_now)  state_d = S_DRAIN;
      S_DRAIN: begin
        if (drain_done) begin
          state_d  = S_IDLE;
          done_out = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Run bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    idx_addr_d = idx_addr_q;
    stop_d     = stop_q;
    accepted_d = accepted_q;
    max_d      = max_q;
    emitted_d  = emitted_q;
    // reserved covers in-flight reads plus FIFO occupancy, so bounding it by
    // FIFO_DEPTH is what guarantees the FIFO cannot overflow.
    reserved_d = reserved_q + RES_W'(index_en_out) - RES_W'(xfer) - RES_W'(squash);
    wr_ptr_d   = wr_ptr_q + {{FIFO_AW{1'b0}}, vtx_push};
    rd_ptr_d   = rd_ptr_q + {{FIFO_AW{1'b0}}, xfer};

    if (start_acc) begin
      idx_addr_d = first_index_in + INDEX_AW'(1);
      stop_d     = 1'b0;
      accepted_d = '0;
      max_d      = max_count_in;
      emitted_d  = '0;
    end else begin
      if (fetch_issue) idx_addr_d = idx_addr_q + INDEX_AW'(1);
      if (stop_now)    stop_d     = 1'b1;
      if (acc_ret)     accepted_d = acc_next;
      if (xfer && (emitted_q != 16'hFFFF)) emitted_d = emitted_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      idx_addr_q <= '0;
      reserved_q <= '0;
      stop_q     <= 1'b0;
      accepted_q <= '0;
      max_q      <= '0;
      emitted_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      idx_pipe_q <= '0;
      vtx_pipe_q <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) tag_pipe_q[i] <= '0;
    end else begin
      idx_addr_q <= idx_addr_d;
      reserved_q <= reserved_d;
      stop_q     <= stop_d;
      accepted_q <= accepted_d;
      max_q      <= max_d;
      emitted_q  <= emitted_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      idx_pipe_q[0] <= index_en_out;
      vtx_pipe_q[0] <= acc_ret;
      tag_pipe_q[0] <= '{vid: ret_vid, mat: ret_mat};
      for (int i = 1; i < MEM_LATENCY; i++) begin
        idx_pipe_q[i] <= idx_pipe_q[i-1];
        vtx_pipe_q[i] <= vtx_pipe_q[i-1];
        tag_pipe_q[i] <= tag_pipe_q[i-1];
      end
    end
  end

  // NOTE: the FIFO storage has no reset; the pointers define which entries
  // are meaningful, and leaving the array unreset lets it map to RAM.
  always_ff @(posedge clk_in) begin
    if (vtx_push) begin
      fifo_mem_q[wr_ptr_q[FIFO_AW-1:0]] <= '{tag: tag_pipe_q[MEM_LATENCY-1],
                                             attr: vertex_data_in};
    end
  end

endmodule

// File: tb/tb_vertex_fetch_stream.sv
module tb_vertex_fetch_stream;

  localparam int L     = 2;
  localparam int IDW   = 12;
  localparam int ATW   = 192;
  localparam int IAW   = 10;
  localparam int VAW   = 10;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [IDW-1:0] vid;
    logic [IDW-1:0] mat;
    logic [ATW-1:0] attr;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [IAW-1:0] first_index;
  logic [15:0]    max_count;
  logic [IAW-1:0] index_addr;
  logic           index_en;
  logic [2*IDW-1:0] index_data;
  logic [VAW-1:0] vertex_addr;
  logic           vertex_en;
  logic [ATW-1:0] vertex_data;
  logic           busy, done;
  logic [15:0]    emitted;

  always #5 clk = ~clk;

  vertex_fetch_stream_if #(.ID_WIDTH(IDW), .ATTR_WIDTH(ATW)) vif ();

  vertex_fetch_stream #(
    .ID_WIDTH(IDW), .ATTR_WIDTH(ATW), .INDEX_AW(IAW), .VERTEX_AW(VAW),
    .MEM_LATENCY(L), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start),
    .first_index_in(first_index), .max_count_in(max_count),
    .index_addr_out(index_addr), .index_en_out(index_en),
    .index_data_in(index_data),
    .vertex_addr_out(vertex_addr), .vertex_en_out(vertex_en),
    .vertex_data_in(vertex_data),
    .out_if(vif.master),
    .busy_out(busy), .done_out(done), .emitted_out(emitted)
  );

  // Expected attribute word for a vertex address.
  function automatic logic [ATW-1:0] attr_of(input logic [VAW-1:0] a);
    return {3{a, 22'h155555, ~a, 22'h2AAAAA}};
  endfunction

  // ---------------------------------------------------------------------------
  // Memory models with fixed read latency L
  // ---------------------------------------------------------------------------
  logic [2*IDW-1:0] index_mem [1024];
  logic [IAW-1:0]   ia_pipe [L] = '{default: '0};
  logic             ia_vld  [L] = '{default: 1'b0};
  logic [VAW-1:0]   va_pipe [L] = '{default: '0};

  always @(posedge clk) begin
    ia_pipe[0] <= index_addr;
    ia_vld[0]  <= rst ? 1'b0 : index_en;
    va_pipe[0] <= vertex_addr;
    for (int i = 1; i < L; i++) begin
      ia_pipe[i] <= ia_pipe[i-1];
      ia_vld[i]  <= rst ? 1'b0 : ia_vld[i-1];
      va_pipe[i] <= va_pipe[i-1];
    end
  end

  assign index_data  = index_mem[ia_pipe[L-1]];
  assign vertex_data = attr_of(va_pipe[L-1]);

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  exp_t           exp_q [$];
  logic [IAW-1:0] idx_log [$];
  int cyc = 0;
  int start_cyc, first_valid_cyc, done_cyc;
  int done_cnt, ven_cnt, res_now, res_max, stable_err;
  logic valid_seen;
  logic hold_q = 1'b0;
  exp_t hold_payload;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples mid-cycle, pops the scoreboard on each transfer.
  always @(negedge clk) begin
    exp_t cur, e;
    cur = '{vid: vif.vertex_id_out, mat: vif.material_out, attr: vif.attr_out};
    if (index_en)  idx_log.push_back(index_addr);
    if (vertex_en) ven_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (vif.valid_out) begin
      valid_seen = 1'b1;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (rst) begin
      res_now = 0;
      hold_q  = 1'b0;
    end else begin
      res_now = res_now + (index_en ? 1 : 0)
                        - ((vif.valid_out && vif.ready_in) ? 1 : 0)
                        - ((ia_vld[L-1] && !vertex_en) ? 1 : 0);
      if (res_now > res_max) res_max = res_now;
      if (hold_q && vif.valid_out && (cur !== hold_payload)) stable_err++;
      hold_q       = vif.valid_out && !vif.ready_in;
      hold_payload = cur;
    end
    if (vif.valid_out && vif.ready_in) begin
      if (exp_q.size() == 0) begin
        check("unexpected_xfer", 256'(vif.vertex_id_out), 256'(12'hFFF));
      end else begin
        e = exp_q.pop_front();
        check("xfer_vid",  256'(cur.vid),  256'(e.vid));
        check("xfer_mat",  256'(cur.mat),  256'(e.mat));
        check("xfer_attr", 256'(cur.attr), 256'(e.attr));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic push_exp(input logic [IDW-1:0] vid, input logic [IDW-1:0] mat);
    exp_q.push_back('{vid: vid, mat: mat, attr: attr_of(vid[VAW-1:0])});
  endtask

  task automatic do_start(input logic [IAW-1:0] fi, input logic [15:0] mc);
    done_cnt        = 0;
    ven_cnt         = 0;
    res_max         = 0;
    stable_err      = 0;
    valid_seen      = 1'b0;
    first_valid_cyc = -1;
    done_cyc        = -1;
    idx_log.delete();
    first_index = fi;
    max_count   = mc;
    start       = 1'b1;
    start_cyc   = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_run(input string name, input int bound);
    int n = 0;
    while (!(done_cnt > 0 && exp_q.size() == 0) && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_timeout"}, 256'(n < bound), 256'(1));
    repeat (4) @(posedge clk);
    #1;
    check({name, "_done_cnt"}, 256'(done_cnt), 256'(1));
    check({name, "_busy"}, 256'(busy), 256'(0));
    check({name, "_left"}, 256'(exp_q.size()), 256'(0));
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_valid"},   256'(vif.valid_out), 256'(0));
    check({name, "_busy"},    256'(busy),          256'(0));
    check({name, "_done"},    256'(done),          256'(0));
    check({name, "_idx_en"},  256'(index_en),      256'(0));
    check({name, "_vtx_en"},  256'(vertex_en),     256'(0));
    check({name, "_idx_a"},   256'(index_addr),    256'(0));
    check({name, "_vtx_a"},   256'(vertex_addr),   256'(0));
    check({name, "_emitted"}, 256'(emitted),       256'(0));
  endtask

  // ---------------------------------------------------------------------------
  // Directed runs
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 1024; i++) index_mem[i] = '1;
    rst = 1'b1; start = 1'b0; first_index = '0; max_count = '0;
    vif.ready_in = 1'b1;
    res_now = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic list 5,6,7,terminator.
    index_mem[0] = {12'd5, 12'h101};
    index_mem[1] = {12'd6, 12'h102};
    index_mem[2] = {12'd7, 12'h103};
    index_mem[3] = {12'hFFF, 12'h000};
    push_exp(12'd5, 12'h101); push_exp(12'd6, 12'h102); push_exp(12'd7, 12'h103);
    do_start(10'd0, 16'd0);
    wait_run("basic", 200);
    check("basic_emitted", 256'(emitted), 256'(3));
    check("basic_latency", 256'(first_valid_cyc - start_cyc), 256'(2*L+1));

    // Same list with the sink stalled for 20 cycles.
    vif.ready_in = 1'b0;
    push_exp(12'd5, 12'h101); push_exp(12'd6, 12'h102); push_exp(12'd7, 12'h103);
    do_start(10'd0, 16'd0);
    repeat (19) @(posedge clk);
    #1;
    vif.ready_in = 1'b1;
    wait_run("stall", 200);
    check("stall_emitted", 256'(emitted), 256'(3));
    check("stall_res_bound", 256'(res_max <= DEPTH), 256'(1));
    check("stall_hold", 256'(stable_err), 256'(0));

    // Longer list under stall: reservation must saturate at the FIFO depth.
    for (int i = 0; i < 12; i++) index_mem[100+i] = {12'(20+i), 12'(12'h200+i)};
    index_mem[112] = {12'hFFF, 12'h000};
    vif.ready_in = 1'b0;
    for (int i = 0; i < 12; i++) push_exp(12'(20+i), 12'(12'h200+i));
    do_start(10'd100, 16'd0);
    repeat (19) @(posedge clk);
    #1;
    vif.ready_in = 1'b1;
    wait_run("long", 300);
    check("long_emitted", 256'(emitted), 256'(12));
    check("long_res_max", 256'(res_max), 256'(DEPTH));
    check("long_hold", 256'(stable_err), 256'(0));

    // Index address wrap 1022,1023,0,1.
    index_mem[1022] = {12'd40, 12'h300};
    index_mem[1023] = {12'd41, 12'h301};
    index_mem[0]    = {12'd42, 12'h302};
    index_mem[1]    = {12'hFFF, 12'h000};
    push_exp(12'd40, 12'h300); push_exp(12'd41, 12'h301); push_exp(12'd42, 12'h302);
    do_start(10'd1022, 16'd0);
    wait_run("wrap", 200);
    check("wrap_emitted", 256'(emitted), 256'(3));
    check("wrap_log_len", 256'(idx_log.size() >= 4), 256'(1));
    begin
      logic [IAW-1:0] want [4];
      want = '{10'd1022, 10'd1023, 10'd0, 10'd1};
      for (int i = 0; i < 4; i++)
        if (i < idx_log.size()) check("wrap_addr", 256'(idx_log[i]), 256'(want[i]));
    end

    // Vertex limit of 2 on a 100-entry list.
    for (int i = 0; i < 100; i++) index_mem[200+i] = {12'(300+i), 12'(12'h400+i)};
    push_exp(12'd300, 12'h400); push_exp(12'd301, 12'h401);
    do_start(10'd200, 16'd2);
    wait_run("max", 200);
    check("max_emitted", 256'(emitted), 256'(2));
    check("max_vtx_reads", 256'(ven_cnt), 256'(2));

    // Empty run: terminator first.
    index_mem[0] = {12'hFFF, 12'h000};
    do_start(10'd0, 16'd0);
    wait_run("empty", 100);
    check("empty_valid", 256'(valid_seen), 256'(0));
    check("empty_vtx_reads", 256'(ven_cnt), 256'(0));
    check("empty_emitted", 256'(emitted), 256'(0));
    check("empty_done_time", 256'((done_cyc - start_cyc) <= L + 2), 256'(1));

    // Reset in the middle of a run, then the same run uninterrupted.
    for (int i = 0; i < 6; i++) index_mem[400+i] = {12'(50+i), 12'(12'h500+i)};
    index_mem[406] = {12'hFFF, 12'h000};
    do_start(10'd400, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    check("midrst_no_done", 256'(done_cnt), 256'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) push_exp(12'(50+i), 12'(12'h500+i));
    do_start(10'd400, 16'd0);
    wait_run("rerun", 200);
    check("rerun_emitted", 256'(emitted), 256'(6));
    check("rerun_latency", 256'(first_valid_cyc - start_cyc), 256'(2*L+1));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
